// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-master round-robin arbiter in front of an SDRAM controller
// One burst at a time: the owner's command is captured at grant and replayed to the controller.
module sdram_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 9
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [LEN_W-1:0]  m0_len,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_wr_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rd_valid,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [LEN_W-1:0]  m1_len,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_wr_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rd_valid,
  output logic              m1_done,
  output logic              sdram_wr_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [DATA_W-1:0] sdram_wr_data,
  output logic [LEN_W-1:0]  sdwr_bytes,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_rd_addr,
  output logic [LEN_W-1:0]  sdrd_bytes,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  input  logic [DATA_W-1:0] sdram_rd_data,
  input  logic              sdram_init_done,
  input  logic              sdram_busy
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              pick;
  logic              gnt;

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    addr_d       = addr_q;
    we_d         = we_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    pick         = 1'b0;

    case (state_q)
      IDLE: begin
        if (sdram_init_done && !sdram_busy && (m0_req || m1_req)) begin
          // On a tie the master that did not own the last burst goes next.
          pick    = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          owner_d = pick;
          we_d    = pick ? m1_we   : m0_we;
          addr_d  = pick ? m1_addr : m0_addr;
          len_d   = pick ? m1_len  : m0_len;
          cnt_d   = '0;
          if (len_d == '0)
            state_d = DONE;
          else
            state_d = we_d ? WRITE : READ;
        end
      end
      WRITE: begin
        if (sdram_wr_ack) begin
          cnt_d = cnt_q + LEN_ONE;
          if (cnt_q == len_q - LEN_ONE)
            state_d = DRAIN;
        end
      end
      READ: begin
        if (sdram_rd_ack) begin
          cnt_d = cnt_q + LEN_ONE;
          if (cnt_q == len_q - LEN_ONE)
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!sdram_busy)
          state_d = DONE;
      end
      DONE: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt           = (state_q != IDLE);
    m0_gnt        = gnt & ~owner_q;
    m1_gnt        = gnt & owner_q;
    m0_wr_ack     = 1'b0;
    m1_wr_ack     = 1'b0;
    m0_rdata      = '0;
    m1_rdata      = '0;
    m0_rd_valid   = 1'b0;
    m1_rd_valid   = 1'b0;
    m0_done       = 1'b0;
    m1_done       = 1'b0;
    sdram_wr_req  = 1'b0;
    sdram_wr_addr = '0;
    sdram_wr_data = '0;
    sdwr_bytes    = '0;
    sdram_rd_req  = 1'b0;
    sdram_rd_addr = '0;
    sdrd_bytes    = '0;

    case (state_q)
      WRITE: begin
        sdram_wr_req  = 1'b1;
        sdram_wr_addr = addr_q;
        sdwr_bytes    = len_q;
        sdram_wr_data = owner_q ? m1_wdata : m0_wdata;
        m0_wr_ack     = sdram_wr_ack & ~owner_q;
        m1_wr_ack     = sdram_wr_ack & owner_q;
      end
      READ: begin
        sdram_rd_req  = 1'b1;
        sdram_rd_addr = addr_q;
        sdrd_bytes    = len_q;
        m0_rdata      = owner_q ? '0 : sdram_rd_data;
        m1_rdata      = owner_q ? sdram_rd_data : '0;
        m0_rd_valid   = sdram_rd_ack & ~owner_q;
        m1_rd_valid   = sdram_rd_ack & owner_q;
      end
      DONE: begin
        m0_done = ~owner_q;
        m1_done = owner_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed, table-driven bench for sdram_arbiter
module tb_sdram_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int LW = 9;

  logic          clk_50m = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [LW-1:0] m0_len = '0, m1_len = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_wr_ack, m0_rd_valid, m0_done;
  logic          m1_gnt, m1_wr_ack, m1_rd_valid, m1_done;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          sdram_wr_req, sdram_rd_req;
  logic [AW-1:0] sdram_wr_addr, sdram_rd_addr;
  logic [DW-1:0] sdram_wr_data;
  logic [LW-1:0] sdwr_bytes, sdrd_bytes;
  logic          sdram_wr_ack = 0, sdram_rd_ack = 0;
  logic [DW-1:0] sdram_rd_data = '0;
  logic          sdram_init_done = 0, sdram_busy = 0;

  int total = 0;
  int bad = 0;

  always #10 clk_50m = ~clk_50m;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk_50m(clk_50m), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_len(m0_len), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_wr_ack(m0_wr_ack), .m0_rdata(m0_rdata), .m0_rd_valid(m0_rd_valid),
    .m0_done(m0_done),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_len(m1_len), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_wr_ack(m1_wr_ack), .m1_rdata(m1_rdata), .m1_rd_valid(m1_rd_valid),
    .m1_done(m1_done),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr), .sdram_wr_data(sdram_wr_data),
    .sdwr_bytes(sdwr_bytes), .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr),
    .sdrd_bytes(sdrd_bytes), .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sdram_rd_data(sdram_rd_data), .sdram_init_done(sdram_init_done), .sdram_busy(sdram_busy)
  );

  typedef struct {
    logic          r0, r1, we0, we1;
    logic [LW-1:0] len0, len1;
    logic          exp_own;
    int            exp_op;  // 0 = zero-length, 1 = write, 2 = read
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_50m);
    #2;
  endtask

  initial begin
    int g;
    int acks;
    logic [DW-1:0] rd_words[3];

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 9'd2, 9'd2, 1'b0, 2};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 9'd2, 9'd2, 1'b1, 2};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 9'd2, 9'd2, 1'b0, 2};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 9'd2, 9'd2, 1'b1, 2};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 9'd3, 1'b1, 1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 9'd1, 9'd2, 1'b0, 1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'd1, 9'd0, 1'b0, 2};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 9'd1, 9'd5, 1'b1, 1};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 9'd0, 9'd0, 1'b0, 0};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 9'd2, 9'd0, 1'b1, 0};

    tick; tick;
    rst = 1'b0;
    tick;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_wr_req", sdram_wr_req, 0);
    chk("rst_rd_req", sdram_rd_req, 0);

    // No grant before the controller reports init done, nor while busy.
    m0_req = 1; m0_we = 1; m0_addr = 24'h000100; m0_len = 9'd4;
    g = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (m0_gnt || m1_gnt) g++;
    end
    chk("no_gnt_before_init", g, 0);
    sdram_init_done = 1; sdram_busy = 1;
    g = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (m0_gnt || m1_gnt) g++;
    end
    chk("no_gnt_while_busy", g, 0);
    sdram_busy = 0;
    tick;
    chk("init_m0_gnt", m0_gnt, 1);
    chk("init_m1_gnt", m1_gnt, 0);
    chk("init_wr_req", sdram_wr_req, 1);
    chk("init_wr_addr", sdram_wr_addr, 24'h000100);
    chk("init_wr_bytes", sdwr_bytes, 4);

    // Four-word write; master inputs scrambled mid-burst must not matter.
    sdram_busy = 1;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      m0_wdata = 16'hC000 + 16'(k);
      sdram_wr_ack = 1;
      #1;
      if (m0_wr_ack) acks++;
      chk("wr_req_during_burst", sdram_wr_req, 1);
      chk("wr_data_pass", sdram_wr_data, 16'hC000 + 16'(k));
      chk("wr_addr_held", sdram_wr_addr, 24'h000100);
      chk("m1_wr_ack_idle", m1_wr_ack, 0);
      if (k == 0) begin
        m0_addr = 24'hFFFFFF; m0_len = 9'd1; m0_we = 0;
      end
      tick;
    end
    sdram_wr_ack = 0;
    chk("wr_ack_count", acks, 4);
    chk("wr_req_dropped", sdram_wr_req, 0);
    chk("drain_gnt_held", m0_gnt, 1);
    sdram_wr_ack = 1;
    #1;
    chk("drain_ack_ignored", m0_wr_ack, 0);
    tick;
    sdram_wr_ack = 0;
    tick;
    chk("no_done_while_busy", m0_done, 0);
    sdram_busy = 0;
    tick;
    chk("wr_done_pulse", m0_done, 1);
    chk("wr_done_gnt", m0_gnt, 1);
    m0_req = 0;
    tick;
    chk("wr_done_cleared", m0_done, 0);
    chk("wr_gnt_released", m0_gnt, 0);

    // Restart arbitration history so the table's first tie goes to m0.
    rst = 1;
    tick;
    rst = 0;
    m0_addr = 24'h001000; m1_addr = 24'h002000;
    m0_wdata = 16'h1100; m1_wdata = 16'h2200;
    for (int i = 0; i < 10; i++) begin
      logic own;
      int nw;
      own = tbl[i].exp_own;
      nw = own ? int'(tbl[i].len1) : int'(tbl[i].len0);
      m0_req = tbl[i].r0; m1_req = tbl[i].r1;
      m0_we = tbl[i].we0; m1_we = tbl[i].we1;
      m0_len = tbl[i].len0; m1_len = tbl[i].len1;
      tick;
      chk($sformatf("tbl%0d_gnt0", i), m0_gnt, !own);
      chk($sformatf("tbl%0d_gnt1", i), m1_gnt, own);
      chk($sformatf("tbl%0d_wr_req", i), sdram_wr_req, tbl[i].exp_op == 1);
      chk($sformatf("tbl%0d_rd_req", i), sdram_rd_req, tbl[i].exp_op == 2);
      if (tbl[i].exp_op == 1) begin
        chk($sformatf("tbl%0d_wr_addr", i), sdram_wr_addr, own ? 24'h002000 : 24'h001000);
        chk($sformatf("tbl%0d_wr_bytes", i), sdwr_bytes, nw);
      end
      if (tbl[i].exp_op == 2) begin
        chk($sformatf("tbl%0d_rd_addr", i), sdram_rd_addr, own ? 24'h002000 : 24'h001000);
        chk($sformatf("tbl%0d_rd_bytes", i), sdrd_bytes, nw);
      end
      if (tbl[i].exp_op != 0) begin
        for (int k = 0; k < nw; k++) begin
          if (tbl[i].exp_op == 1) sdram_wr_ack = 1;
          else begin
            sdram_rd_ack = 1;
            sdram_rd_data = 16'h3000 + 16'(k);
          end
          #1;
          if (tbl[i].exp_op == 1) begin
            chk($sformatf("tbl%0d_wr_ack_own", i), own ? m1_wr_ack : m0_wr_ack, 1);
            chk($sformatf("tbl%0d_wr_ack_other", i), own ? m0_wr_ack : m1_wr_ack, 0);
            chk($sformatf("tbl%0d_wr_data", i), sdram_wr_data, own ? 16'h2200 : 16'h1100);
          end else begin
            chk($sformatf("tbl%0d_rd_valid_own", i), own ? m1_rd_valid : m0_rd_valid, 1);
            chk($sformatf("tbl%0d_rd_valid_other", i), own ? m0_rd_valid : m1_rd_valid, 0);
            chk($sformatf("tbl%0d_rdata", i), own ? m1_rdata : m0_rdata, 16'h3000 + 16'(k));
          end
          tick;
        end
        sdram_wr_ack = 0; sdram_rd_ack = 0;
        chk($sformatf("tbl%0d_req_dropped", i), sdram_wr_req | sdram_rd_req, 0);
        tick;
      end
      chk($sformatf("tbl%0d_done_own", i), own ? m1_done : m0_done, 1);
      chk($sformatf("tbl%0d_done_other", i), own ? m0_done : m1_done, 0);
      m0_req = 0; m1_req = 0;
      tick;
      chk($sformatf("tbl%0d_done_clear", i), m0_done | m1_done, 0);
    end

    // m1 read burst with specific data words.
    rd_words[0] = 16'hA5A5; rd_words[1] = 16'h5A5A; rd_words[2] = 16'h1234;
    m1_req = 1; m1_we = 0; m1_addr = 24'h000ABC; m1_len = 9'd3;
    tick;
    chk("rd3_m1_gnt", m1_gnt, 1);
    chk("rd3_rd_req", sdram_rd_req, 1);
    chk("rd3_rd_bytes", sdrd_bytes, 3);
    for (int k = 0; k < 3; k++) begin
      sdram_rd_ack = 1;
      sdram_rd_data = rd_words[k];
      #1;
      chk("rd3_m1_valid", m1_rd_valid, 1);
      chk("rd3_m1_rdata", m1_rdata, rd_words[k]);
      chk("rd3_m0_valid", m0_rd_valid, 0);
      chk("rd3_m0_rdata", m0_rdata, 0);
      tick;
    end
    sdram_rd_ack = 1; sdram_busy = 1;
    #1;
    chk("rd3_drain_ignored", m1_rd_valid, 0);
    chk("rd3_req_dropped", sdram_rd_req, 0);
    tick;
    sdram_rd_ack = 0; sdram_busy = 0;
    tick;
    chk("rd3_done", m1_done, 1);
    m1_req = 0;
    tick;

    // Reset in the middle of an 8-word write.
    m0_req = 1; m0_we = 1; m0_addr = 24'h000200; m0_len = 9'd8;
    tick;
    chk("rstm_gnt", m0_gnt, 1);
    for (int k = 0; k < 2; k++) begin
      sdram_wr_ack = 1;
      tick;
    end
    sdram_wr_ack = 0;
    rst = 1; m1_req = 1; m1_we = 1; m1_len = 9'd1;
    tick;
    chk("rstm_m0_gnt", m0_gnt, 0);
    chk("rstm_wr_req", sdram_wr_req, 0);
    chk("rstm_wr_addr", sdram_wr_addr, 0);
    chk("rstm_wr_bytes", sdwr_bytes, 0);
    chk("rstm_m0_done", m0_done, 0);
    chk("rstm_m1_gnt", m1_gnt, 0);
    rst = 0;
    tick;
    chk("rstm_tie_m0_gnt", m0_gnt, 1);
    chk("rstm_tie_m1_gnt", m1_gnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
